csr_seq: RTL and testbench
==========================

# csr_seq

Multi-cycle sequencer in front of the machine-mode CSR register file. It accepts one CSR or trap request at a time from decode/execute and drives the register file's single address/write port. CSRRW/CSRRS/CSRRC requests complete as a read-modify-write. ECALL and MRET expand into an ordered series of CSR accesses. It returns the old CSR value, or a PC redirect target, through a valid/ready response.

## Interface
Parameters:
- ADDR_WIDTH, 12, CSR address width
- DATA_WIDTH, 64, CSR/data width

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET; others illegal
- req_addr  in  ADDR_WIDTH  CSR address (CSR ops only)
- req_src  in  DATA_WIDTH  rs1 value (CSR ops only)
- req_pc  in  DATA_WIDTH  PC of the instruction (ECALL only)
- resp_valid  out  1  response present; held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_WIDTH  old CSR value (CSR ops), else 0
- resp_redirect  out  1  response carries a PC redirect (ECALL/MRET)
- resp_target  out  DATA_WIDTH  redirect target
- resp_err  out  1  illegal op or unknown CSR address
- csr_addr  out  ADDR_WIDTH  register-file address
- csr_wen  out  1  register-file write strobe
- csr_wdata  out  DATA_WIDTH  register-file write data
- csr_rdata  in  DATA_WIDTH  register-file read data, combinational from csr_addr

## Operation
- Handshakes: accept on req_valid && req_ready; latch op/addr/src/pc. Response handed off on resp_valid && resp_ready.
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. Any other address -> resp_err, no write.
- FSM states: IDLE, ACCESS, TRAP_EPC, TRAP_CAUSE, TRAP_STAT, TRAP_VEC, MRET_STAT, MRET_EPC, RESP.
- IDLE:
  - CSR op -> ACCESS; ECALL -> TRAP_EPC; MRET -> MRET_STAT.
  - Illegal op -> RESP with resp_err=1.
- ACCESS: csr_addr=addr. Capture old=csr_rdata. Write in the same cycle:
  - CSRRW: wdata=src.
  - CSRRS: old|src.
  - CSRRC: old&~src.
  - CSRRS/CSRRC with src==0: csr_wen=0.
  - Next state RESP.
- TRAP_EPC: write mepc=pc.
- TRAP_CAUSE: write mcause=11.
- TRAP_STAT: read-modify-write mstatus: MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(bits12:11)<=2'b11.
- TRAP_VEC: read mtvec; target=mtvec with bits[1:0] cleared. Next state RESP with redirect=1.
- MRET_STAT: read-modify-write mstatus: MIE<=MPIE, MPIE<=1, MPP<=0.
- MRET_EPC: read mepc; target=mepc. Next state RESP with redirect=1.
- RESP: resp_valid=1 with outputs stable. On resp_ready -> IDLE.
- csr_wen is asserted in at most one state per cycle and never in IDLE or RESP.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_redirect=0, resp_err=0.
  - resp_rdata=0, resp_target=0, csr_wen=0, csr_addr=0, csr_wdata=0.
- Latency from accept cycle T to first resp_valid:
  - CSR op: T+2.
  - ECALL: T+5.
  - MRET: T+3.
  - Illegal op: T+1.
- Back-to-back: if resp_ready is high in the first RESP cycle, the next request is accepted one cycle after the handoff (IDLE cycle).
- Register-file writes land on the posedge ending the strobed state. A later state reading the same CSR sees the new value.
- Reset during any state: returns to IDLE on the next edge. No csr_wen in a cycle with rst=1. Writes already committed are not undone.
- resp_ready held low: stay in RESP indefinitely, outputs unchanged, req_ready=0.

## Structure
- Package csr_pkg:
  - CSR address localparams.
  - op enum (csr_op_e).
  - FSM state enum.
  - MCAUSE_ECALL_M=11.
  - mstatus bit-index constants (MIE=3, MPIE=7, MPP=12:11).
- Sub-module csr_rmw_alu: combinational; takes op, old, src; produces wdata and a write-enable qualifier. Shared by ACCESS and the mstatus update states via a small function selector.

## Test plan
- CSRRW 0x305 src=0x8000_0000 (mtvec was 0) -> resp_rdata=0 at T+2; subsequent CSRRS 0x305 src=0 returns 0x8000_0000 with no csr_wen.
- CSRRC 0x300 src=0x8 with mstatus=0xA_0000_1808 -> resp_rdata=0xA_0000_1808; mstatus becomes 0xA_0000_1800.
- ECALL pc=0x8000_0100, mtvec=0x8000_0003, mstatus.MIE=1 -> mepc=0x8000_0100, mcause=11, MIE=0, MPIE=1, MPP=3; resp_redirect=1, target=0x8000_0000 at T+5.
- MRET after the above -> MIE=1, MPIE=1, MPP=0; target=0x8000_0100 at T+3.
- req_op=7, or CSRRW to 0x344 -> resp_err=1, no csr_wen pulse at any cycle.
- rst asserted in TRAP_CAUSE -> next cycle IDLE, req_ready=1, mcause unchanged, mepc already updated; resp_ready held low 10 cycles -> resp fields stable, req_ready=0 throughout.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types and constants for the machine-mode CSR sequencer.
package csr_pkg;

  // Machine-mode CSR addresses handled by the sequencer
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Exception code for an environment call from M-mode
  localparam int MCAUSE_ECALL_M = 11;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Request opcodes as presented on req_op
  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } csr_op_e;

  // Sequencer states
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ACCESS     = 4'd1,
    TRAP_EPC   = 4'd2,
    TRAP_CAUSE = 4'd3,
    TRAP_STAT  = 4'd4,
    TRAP_VEC   = 4'd5,
    MRET_STAT  = 4'd6,
    MRET_EPC   = 4'd7,
    RESP       = 4'd8
  } state_e;

  // Function selector for the read-modify-write datapath
  typedef enum logic [2:0] {
    RMW_WRITE = 3'd0,
    RMW_SET   = 3'd1,
    RMW_CLEAR = 3'd2,
    RMW_TRAP  = 3'd3,
    RMW_MRET  = 3'd4
  } rmw_fn_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write datapath: turns an old CSR value and an
// operand into new write data plus a qualifier saying whether to write at all.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  rmw_fn_e               fn,
  input  logic [DATA_WIDTH-1:0] old,
  input  logic [DATA_WIDTH-1:0] src,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wen_ok
);

  // Compute new CSR value; set/clear with a zero operand must leave the CSR untouched
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    wdata  = old;
    wen_ok = 1'b1;
    case (fn)
      RMW_WRITE: wdata = src;
      RMW_SET: begin
        wdata  = old | src;
        wen_ok = |src;
      end
      RMW_CLEAR: begin
        wdata  = old & ~src;
        wen_ok = |src;
      end
      RMW_TRAP: begin
        wdata[MSTATUS_MPIE]                  = old[MSTATUS_MIE];
        wdata[MSTATUS_MIE]                   = 1'b0;
        wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      RMW_MRET: begin
        wdata[MSTATUS_MIE]                   = old[MSTATUS_MPIE];
        wdata[MSTATUS_MPIE]                  = 1'b1;
        wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
      end
      default: begin
        wdata  = old;
        wen_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_seq.sv
// Multi-cycle sequencer driving the single port of the machine-mode CSR file.
// CSR instructions become one read-modify-write cycle; ECALL and MRET expand
// into an ordered series of CSR accesses ending in a PC redirect response.
module csr_seq
  import csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic [DATA_WIDTH-1:0] req_pc,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_redirect,
  output logic [DATA_WIDTH-1:0] resp_target,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic                  csr_wen,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata
);

  localparam logic [ADDR_WIDTH-1:0] A_MSTATUS = ADDR_WIDTH'(CSR_MSTATUS);
  localparam logic [ADDR_WIDTH-1:0] A_MTVEC   = ADDR_WIDTH'(CSR_MTVEC);
  localparam logic [ADDR_WIDTH-1:0] A_MEPC    = ADDR_WIDTH'(CSR_MEPC);
  localparam logic [ADDR_WIDTH-1:0] A_MCAUSE  = ADDR_WIDTH'(CSR_MCAUSE);
  localparam logic [DATA_WIDTH-1:0] VEC_MASK  = ~DATA_WIDTH'(3);

  state_e                state, state_next;
  csr_op_e               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic [DATA_WIDTH-1:0] pc_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic                  redirect_q;
  logic                  err_q;

  rmw_fn_e               alu_fn;
  logic [DATA_WIDTH-1:0] alu_wdata;
  logic                  alu_wen_ok;
  logic                  accept;
  logic                  op_legal;
  logic                  addr_known;

  assign accept     = req_valid && req_ready;
  assign op_legal   = req_op <= 3'(OP_MRET);
  assign addr_known = (addr_q == A_MSTATUS) || (addr_q == A_MTVEC) ||
                      (addr_q == A_MEPC)    || (addr_q == A_MCAUSE);

  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_target   = target_q;
  assign resp_redirect = redirect_q;
  assign resp_err      = err_q;

  csr_rmw_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .fn     (alu_fn),
    .old    (csr_rdata),
    .src    (src_q),
    .wdata  (alu_wdata),
    .wen_ok (alu_wen_ok)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Latch the request fields on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_CSRRW;
      addr_q <= '0;
      src_q  <= '0;
      pc_q   <= '0;
    end else if (accept) begin
      op_q   <= csr_op_e'(req_op);
      addr_q <= req_addr;
      src_q  <= req_src;
      pc_q   <= req_pc;
    end
  end

  // Next-state logic and register-file port control
  always_comb begin
    state_next = state;
    csr_addr   = '0;
    csr_wen    = 1'b0;
    csr_wdata  = '0;
    alu_fn     = RMW_WRITE;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_next = ACCESS;
            OP_ECALL:                     state_next = TRAP_EPC;
            OP_MRET:                      state_next = MRET_STAT;
            default:                      state_next = RESP;
          endcase
        end
      end
      ACCESS: begin
        case (op_q)
          OP_CSRRW: alu_fn = RMW_WRITE;
          OP_CSRRS: alu_fn = RMW_SET;
          default:  alu_fn = RMW_CLEAR;
        endcase
        csr_addr   = addr_q;
        csr_wen    = addr_known && alu_wen_ok;
        csr_wdata  = alu_wdata;
        state_next = RESP;
      end
      TRAP_EPC: begin
        csr_addr   = A_MEPC;
        csr_wen    = 1'b1;
        csr_wdata  = pc_q;
        state_next = TRAP_CAUSE;
      end
      TRAP_CAUSE: begin
        csr_addr   = A_MCAUSE;
        csr_wen    = 1'b1;
        csr_wdata  = DATA_WIDTH'(MCAUSE_ECALL_M);
        state_next = TRAP_STAT;
      end
      TRAP_STAT: begin
        alu_fn     = RMW_TRAP;
        csr_addr   = A_MSTATUS;
        csr_wen    = alu_wen_ok;
        csr_wdata  = alu_wdata;
        state_next = TRAP_VEC;
      end
      TRAP_VEC: begin
        csr_addr   = A_MTVEC;
        state_next = RESP;
      end
      MRET_STAT: begin
        alu_fn     = RMW_MRET;
        csr_addr   = A_MSTATUS;
        csr_wen    = alu_wen_ok;
        csr_wdata  = alu_wdata;
        state_next = MRET_EPC;
      end
      MRET_EPC: begin
        csr_addr   = A_MEPC;
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A reset cycle must never commit a register-file write
    if (rst) csr_wen = 1'b0;
  end

  // Response registers: cleared on accept, filled by the state that produces them
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rdata_q    <= '0;
            target_q   <= '0;
            redirect_q <= 1'b0;
            err_q      <= !op_legal;
          end
        end
        ACCESS: begin
          rdata_q <= addr_known ? csr_rdata : '0;
          err_q   <= !addr_known;
        end
        TRAP_VEC: begin
          target_q   <= csr_rdata & VEC_MASK;
          redirect_q <= 1'b1;
        end
        MRET_EPC: begin
          target_q   <= csr_rdata;
          redirect_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_seq.sv
// Directed bench for csr_seq with a behavioural CSR file and a response scoreboard.
module tb_csr_seq;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [63:0] req_src;
  logic [63:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_redirect;
  logic [63:0] resp_target;
  logic        resp_err;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;

  logic [63:0] mstatus_r, mtvec_r, mepc_r, mcause_r;
  logic        load;
  int          wen_count;
  int          bad_wr;
  int          wen_in_rst;

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic        redirect;
    logic [63:0] target;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csr_seq dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_src       (req_src),
    .req_pc        (req_pc),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_redirect (resp_redirect),
    .resp_target   (resp_target),
    .resp_err      (resp_err),
    .csr_addr      (csr_addr),
    .csr_wen       (csr_wen),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata)
  );

  // Register file read port
  always_comb begin
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_r;
      CSR_MTVEC:   csr_rdata = mtvec_r;
      CSR_MEPC:    csr_rdata = mepc_r;
      CSR_MCAUSE:  csr_rdata = mcause_r;
      default:     csr_rdata = '0;
    endcase
  end

  // Register file write port plus write-strobe bookkeeping
  always @(posedge clk) begin
    if (load) begin
      mstatus_r <= 64'hA_0000_1808;
      mtvec_r   <= '0;
      mepc_r    <= '0;
      mcause_r  <= '0;
    end else if (csr_wen) begin
      wen_count <= wen_count + 1;
      if (rst) wen_in_rst <= wen_in_rst + 1;
      case (csr_addr)
        CSR_MSTATUS: mstatus_r <= csr_wdata;
        CSR_MTVEC:   mtvec_r   <= csr_wdata;
        CSR_MEPC:    mepc_r    <= csr_wdata;
        CSR_MCAUSE:  mcause_r  <= csr_wdata;
        default:     bad_wr    <= bad_wr + 1;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request and wait (bounded) for its response; returns cycles from accept
  task automatic send(input logic [2:0] op, input logic [11:0] addr,
                      input logic [63:0] src, input logic [63:0] pc, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_src   = src;
    req_pc    = pc;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Pop the oldest expectation and compare it to the response on the port
  task automatic compare_resp(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_valid"},    64'(resp_valid), 64'd1);
    check({e.tag, "_latency"},  64'(lat), 64'(e.lat));
    check({e.tag, "_rdata"},    resp_rdata, e.rdata);
    check({e.tag, "_redirect"}, 64'(resp_redirect), 64'(e.redirect));
    check({e.tag, "_target"},   resp_target, e.target);
    check({e.tag, "_err"},      64'(resp_err), 64'(e.err));
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [11:0] addr,
                        input logic [63:0] src, input logic [63:0] pc,
                        input logic [63:0] e_rdata, input logic e_redir,
                        input logic [63:0] e_target, input logic e_err, input int e_lat,
                        input int e_writes);
    int lat;
    int w0;
    exp_t e;
    e.tag = tag; e.rdata = e_rdata; e.redirect = e_redir;
    e.target = e_target; e.err = e_err; e.lat = e_lat;
    sb.push_back(e);
    w0 = wen_count;
    send(op, addr, src, pc, lat);
    compare_resp(lat);
    check({tag, "_writes"}, 64'(wen_count - w0), 64'(e_writes));
  endtask

  initial begin
    int lat;
    wen_count  = 0;
    bad_wr     = 0;
    wen_in_rst = 0;
    rst        = 1'b1;
    load       = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_addr   = '0;
    req_src    = '0;
    req_pc     = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_req_ready",     64'(req_ready), 64'd1);
    check("rst_resp_valid",    64'(resp_valid), 64'd0);
    check("rst_resp_redirect", 64'(resp_redirect), 64'd0);
    check("rst_resp_err",      64'(resp_err), 64'd0);
    check("rst_resp_rdata",    resp_rdata, 64'd0);
    check("rst_resp_target",   resp_target, 64'd0);
    check("rst_csr_wen",       64'(csr_wen), 64'd0);
    check("rst_csr_addr",      64'(csr_addr), 64'd0);
    check("rst_csr_wdata",     csr_wdata, 64'd0);

    // CSR read-modify-write operations
    do_req("rw_mtvec", 3'd0, 12'h305, 64'h8000_0000, 64'd0,
           64'd0, 1'b0, 64'd0, 1'b0, 2, 1);
    check("mtvec_after_rw", mtvec_r, 64'h8000_0000);
    do_req("rs_zero_mtvec", 3'd1, 12'h305, 64'd0, 64'd0,
           64'h8000_0000, 1'b0, 64'd0, 1'b0, 2, 0);
    do_req("rc_mstatus", 3'd2, 12'h300, 64'h8, 64'd0,
           64'hA_0000_1808, 1'b0, 64'd0, 1'b0, 2, 1);
    check("mstatus_after_rc", mstatus_r, 64'hA_0000_1800);
    do_req("rs_mstatus", 3'd1, 12'h300, 64'h8, 64'd0,
           64'hA_0000_1800, 1'b0, 64'd0, 1'b0, 2, 1);
    check("mstatus_after_rs", mstatus_r, 64'hA_0000_1808);
    do_req("rw_mtvec2", 3'd0, 12'h305, 64'h8000_0003, 64'd0,
           64'h8000_0000, 1'b0, 64'd0, 1'b0, 2, 1);

    // ECALL trap entry and MRET return
    do_req("ecall", 3'd3, 12'h000, 64'd0, 64'h8000_0100,
           64'd0, 1'b1, 64'h8000_0000, 1'b0, 5, 3);
    check("ecall_mepc",    mepc_r, 64'h8000_0100);
    check("ecall_mcause",  mcause_r, 64'd11);
    check("ecall_mstatus", mstatus_r, 64'hA_0000_1880);
    do_req("mret", 3'd4, 12'h000, 64'd0, 64'd0,
           64'd0, 1'b1, 64'h8000_0100, 1'b0, 3, 1);
    check("mret_mstatus", mstatus_r, 64'hA_0000_0088);

    // Error cases: illegal op and unknown CSR address
    do_req("illegal_op", 3'd7, 12'h300, 64'hFF, 64'd0,
           64'd0, 1'b0, 64'd0, 1'b1, 1, 0);
    do_req("unknown_csr", 3'd0, 12'h344, 64'h1234, 64'd0,
           64'd0, 1'b0, 64'd0, 1'b1, 2, 0);
    check("no_bad_writes", 64'(bad_wr), 64'd0);
    do_req("rw_mcause", 3'd0, 12'h342, 64'h55, 64'd0,
           64'd11, 1'b0, 64'd0, 1'b0, 2, 1);

    // Reset asserted while the trap sequence is in TRAP_CAUSE
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_pc    = 64'h8000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_cause_addr", 64'(csr_addr), 64'h342);
    rst = 1'b1;
    #1;
    check("abort_wen_gated", 64'(csr_wen), 64'd0);
    @(negedge clk);
    check("abort_req_ready",  64'(req_ready), 64'd1);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_mcause",     mcause_r, 64'h55);
    check("abort_mepc",       mepc_r, 64'h8000_0200);
    check("abort_no_rst_wen", 64'(wen_in_rst), 64'd0);
    rst = 1'b0;

    // Consumer stalls the response for ten cycles
    resp_ready = 1'b0;
    begin
      exp_t e;
      e.tag = "stall_rd_mepc"; e.rdata = 64'h8000_0200; e.redirect = 1'b0;
      e.target = 64'd0; e.err = 1'b0; e.lat = 2;
      sb.push_back(e);
    end
    send(3'd1, 12'h341, 64'd0, 64'd0, lat);
    compare_resp(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_resp_valid", 64'(resp_valid), 64'd1);
      check("stall_req_ready",  64'(req_ready), 64'd0);
      check("stall_rdata",      resp_rdata, 64'h8000_0200);
      check("stall_err",        64'(resp_err), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_idle", 64'(req_ready), 64'd1);
    check("stall_release_valid", 64'(resp_valid), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
